tmul_row_engine: RTL and testbench

//  Parametrised, time-multiplexed successor to the 16-stage unrolled TMUL row pipeline.
//  - Computes one FP16 output row C[0..N-1] = sum_k A[k]*B[k][0..N-1] over a streamed K dimension.
//  - Uses a single N-lane FMA row plus an accumulator register.
//  - K is variable per packet, up to K_MAX; valid/ready on input beats and on the result.
//  - Sits between the tile-load unit (A element + B row per beat) and the tile writeback buffer.

---
 rtl/tmul_pkg.sv | 103 ++++++++++
 rtl/tmul_row_engine_if.sv | 42 ++++
 rtl/tmul_fma_lane_row.sv | 19 +
 rtl/tmul_row_engine.sv | 106 ++++++++++
 tb/tb_tmul_row_engine.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/tmul_pkg.sv
// Shared types, constants and FP16 helpers for the TMUL row engine.
// Consumers: tmul_fma_lane_row and tmul_row_engine.
package tmul_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;
    localparam int LANES_MAX = 64;
    localparam int ROW_MAX_W = FP16_W * LANES_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} tmul_state_e;

    function automatic logic [FP16_W-1:0] lane(
        input logic [ROW_MAX_W-1:0] row,
        input int i
    );
        return row[i*FP16_W +: FP16_W];
    endfunction

    // Exact a*b+c on a fixed-point grid with LSB 2^-48, then one RNE rounding.
    function automatic logic [15:0] fp16_fma(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [15:0] c
    );
        logic        sp, sc, sr;
        logic        nan_in, inv, p_inf, c_inf, a_zero, b_zero;
        logic [4:0]  ea, eb, ec;
        logic [10:0] ma, mb, mc, q;
        logic [21:0] mp;
        logic [81:0] pm, cm, sm, smask;
        logic [6:0]  p, l;
        logic [16:0] base, r;
        logic        g, st, up;
        logic [15:0] res;

        sp = a[15] ^ b[15];
        sc = c[15];
        ea = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
        eb = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
        ec = (c[14:10] == 5'd0) ? 5'd1 : c[14:10];
        ma = {a[14:10] != 5'd0, a[9:0]};
        mb = {b[14:10] != 5'd0, b[9:0]};
        mc = {c[14:10] != 5'd0, c[9:0]};

        nan_in = ((&a[14:10]) & (|a[9:0]))
               | ((&b[14:10]) & (|b[9:0]))
               | ((&c[14:10]) & (|c[9:0]));
        a_zero = (a[14:0] == 15'd0);
        b_zero = (b[14:0] == 15'd0);
        p_inf  = ((&a[14:10]) & ~(|a[9:0]))
               | ((&b[14:10]) & ~(|b[9:0]));
        c_inf  = (&c[14:10]) & ~(|c[9:0]);
        inv    = nan_in
               | (p_inf & (a_zero | b_zero))
               | (p_inf & c_inf & (sp != sc));

        mp = 22'(ma) * 22'(mb);
        pm = 82'(mp) << (7'(ea) + 7'(eb) - 7'd2);
        cm = 82'(mc) << (7'(ec) + 7'd23);

        if (sp == sc) begin
            sm = pm + cm;
            sr = sp;
        end else if (pm >= cm) begin
            sm = pm - cm;
            sr = sp;
        end else begin
            sm = cm - pm;
            sr = sc;
        end

        p = '0;
        for (int i = 0; i < 82; i++) begin
            if (sm[i]) p = 7'(i);
        end

        // Below bit 35 the quantum is fixed at 2^-24 (subnormal / min exponent).
        if (p > 7'd34) begin
            l    = p - 7'd10;
            base = 17'(p - 7'd34) << 10;
        end else begin
            l    = 7'd24;
            base = '0;
        end

        q     = 11'(sm >> l);
        g     = sm[l - 7'd1];
        smask = (82'd1 << (l - 7'd1)) - 82'd1;
        st    = |(sm & smask);
        up    = g & (st | q[0]);
        r     = base + 17'(q) + 17'(up);

        if (inv)                 res = FP16_QNAN;
        else if (p_inf)          res = {sp, 15'h7C00};
        else if (c_inf)          res = {sc, 15'h7C00};
        else if (sm == '0)       res = {sp & sc, 15'h0000};
        else if (r >= 17'h7C00)  res = {sr, 15'h7C00};
        else                     res = {sr, r[14:0]};
        return res;
    endfunction

endpackage

// File: rtl/tmul_row_engine_if.sv
// Beat-in / row-out handshake bundle of the TMUL row engine.
// c_load/c_row exist only when TMUL_ACC_INIT_EN is defined.
interface tmul_row_engine_if #(
    parameter int N     = 32,
    parameter int K_MAX = 16
);
    localparam int KW = $clog2(K_MAX + 1);

    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_a;
    logic [N*16-1:0] in_b;
    logic            in_last;
`ifdef TMUL_ACC_INIT_EN
    logic            c_load;
    logic [N*16-1:0] c_row;
`endif
    logic            out_valid;
    logic            out_ready;
    logic [N*16-1:0] out_data;
    logic [KW-1:0]   out_k;
    logic            out_err;

    modport master (
        output in_valid, in_a, in_b, in_last,
`ifdef TMUL_ACC_INIT_EN
        output c_load, c_row,
`endif
        output out_ready,
        input  in_ready, out_valid, out_data, out_k, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last,
`ifdef TMUL_ACC_INIT_EN
        input  c_load, c_row,
`endif
        input  out_ready,
        output in_ready, out_valid, out_data, out_k, out_err
    );

endinterface

// File: rtl/tmul_fma_lane_row.sv
// N independent FP16 FMA lanes: y[i] = a * b[i] + c[i], a broadcast.
// Purely combinational; no cross-lane interaction.
module tmul_fma_lane_row
    import tmul_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [FP16_W-1:0]   a,
    input  logic [N*FP16_W-1:0] b,
    input  logic [N*FP16_W-1:0] c,
    output logic [N*FP16_W-1:0] y
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign y[i*FP16_W +: FP16_W] =
            fp16_fma(a, lane(ROW_MAX_W'(b), i), lane(ROW_MAX_W'(c), i));
    end

endmodule

// File: rtl/tmul_row_engine.sv
// Time-multiplexed TMUL row engine: one FMA row plus accumulator over K beats.
// Optional TMUL_ACC_INIT_EN seeds the first beat's addend from c_row.
module tmul_row_engine
    import tmul_pkg::*;
#(
    parameter int N     = 32,
    parameter int K_MAX = 16
) (
    input logic clk,
    input logic rst,
    tmul_row_engine_if.slave bus
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int W  = N * FP16_W;

    tmul_state_e   state, state_n;
    logic [W-1:0]  acc, acc_n;
    logic [W-1:0]  seed, fma_c, fma_y;
    logic [KW-1:0] cnt, cnt_n, cnt_inc;
    logic          err, err_n;
    logic          take;

`ifdef TMUL_ACC_INIT_EN
    assign seed = bus.c_load ? bus.c_row : {N{FP16_ZERO}};
`else
    assign seed = {N{FP16_ZERO}};
`endif

    assign fma_c = (state == IDLE) ? seed : acc;

    tmul_fma_lane_row #(.N(N)) u_row (
        .a (bus.in_a),
        .b (bus.in_b),
        .c (fma_c),
        .y (fma_y)
    );

    assign bus.in_ready  = (state != DONE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = acc;
    assign bus.out_k     = cnt;
    assign bus.out_err   = err;

    assign take    = bus.in_valid & bus.in_ready;
    assign cnt_inc = cnt + KW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        err_n   = err;
        unique case (state)
            IDLE: begin
                if (take) begin
                    acc_n = fma_y;
                    cnt_n = KW'(1);
                    if (bus.in_last || (K_MAX == 1)) begin
                        state_n = DONE;
                        err_n   = ~bus.in_last;
                    end else begin
                        state_n = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (take) begin
                    acc_n = fma_y;
                    cnt_n = cnt_inc;
                    if (bus.in_last) begin
                        state_n = DONE;
                    end else if (cnt_inc == KW'(K_MAX)) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                    acc_n   = '0;
                    cnt_n   = '0;
                    err_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tmul_row_engine.sv
// Directed self-checking bench for tmul_row_engine (N=32, K_MAX=16).
// Define TMUL_ACC_INIT_EN to also exercise the c_row seed path.
module tb_tmul_row_engine;

    localparam int N     = 32;
    localparam int K_MAX = 16;
    localparam int W     = N * 16;

    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    tmul_row_engine_if #(.N(N), .K_MAX(K_MAX)) bus ();

    tmul_row_engine #(.N(N), .K_MAX(K_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] rep(input logic [15:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[i*16 +: 16] = x;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [15:0] a, input logic [W-1:0] b,
                        input logic last);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_vld0"}, W'(bus.out_valid), W'(0));
        chk({tag, "_rdy1"}, W'(bus.in_ready), W'(1));
        chk({tag, "_k0"},   W'(bus.out_k), W'(0));
        chk({tag, "_err0"}, W'(bus.out_err), W'(0));
    endtask

    logic [W-1:0] bmix, emix;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
`ifdef TMUL_ACC_INIT_EN
        bus.c_load    = 1'b0;
        bus.c_row     = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld",  W'(bus.out_valid), W'(0));
        chk("rst_rdy",  W'(bus.in_ready), W'(1));
        chk("rst_k",    W'(bus.out_k), W'(0));
        chk("rst_err",  W'(bus.out_err), W'(0));
        chk("rst_data", bus.out_data, W'(0));
        rst = 1'b0;

        // K=1, 1*2
        beat(16'h3C00, rep(16'h4000), 1'b1);
        chk("k1_vld",  W'(bus.out_valid), W'(1));
        chk("k1_rdy",  W'(bus.in_ready), W'(0));
        chk("k1_data", bus.out_data, rep(16'h4000));
        chk("k1_k",    W'(bus.out_k), W'(1));
        chk("k1_err",  W'(bus.out_err), W'(0));
        drain("k1");

        // K=3, 1*1 three times
        beat(16'h3C00, rep(16'h3C00), 1'b0);
        chk("k3_b1_vld", W'(bus.out_valid), W'(0));
        beat(16'h3C00, rep(16'h3C00), 1'b0);
        beat(16'h3C00, rep(16'h3C00), 1'b1);
        chk("k3_vld",  W'(bus.out_valid), W'(1));
        chk("k3_data", bus.out_data, rep(16'h4200));
        chk("k3_k",    W'(bus.out_k), W'(3));

        // backpressure with junk beats offered
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h4000;
        bus.in_b     = rep(16'h4400);
        bus.in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_vld",  W'(bus.out_valid), W'(1));
            chk("bp_rdy",  W'(bus.in_ready), W'(0));
            chk("bp_data", bus.out_data, rep(16'h4200));
            chk("bp_k",    W'(bus.out_k), W'(3));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        drain("bp");

        // per-lane rounding / cancellation: acc=1.0 then 1*b
        for (int i = 0; i < N; i++) begin
            unique case (i % 4)
                0: begin bmix[i*16 +: 16] = 16'h1000; emix[i*16 +: 16] = 16'h3C00; end
                1: begin bmix[i*16 +: 16] = 16'h1001; emix[i*16 +: 16] = 16'h3C01; end
                2: begin bmix[i*16 +: 16] = 16'hBC00; emix[i*16 +: 16] = 16'h0000; end
                default: begin bmix[i*16 +: 16] = 16'h4000; emix[i*16 +: 16] = 16'h4200; end
            endcase
        end
        beat(16'h3C00, rep(16'h3C00), 1'b0);
        beat(16'h3C00, bmix, 1'b1);
        chk("mix_data", bus.out_data, emix);
        chk("mix_k",    W'(bus.out_k), W'(2));
        drain("mix");

        // 2*3 = 6
        beat(16'h4000, rep(16'h4200), 1'b1);
        chk("mul6_data", bus.out_data, rep(16'h4600));
        drain("mul6");

        // overflow at K_MAX without last
        for (int k = 0; k < K_MAX - 1; k++) beat(16'h3C00, rep(16'h3C00), 1'b0);
        chk("ovf15_vld", W'(bus.out_valid), W'(0));
        chk("ovf15_k",   W'(bus.out_k), W'(15));
        beat(16'h3C00, rep(16'h3C00), 1'b0);
        chk("ovf_vld",  W'(bus.out_valid), W'(1));
        chk("ovf_data", bus.out_data, rep(16'h4C00));
        chk("ovf_k",    W'(bus.out_k), W'(16));
        chk("ovf_err",  W'(bus.out_err), W'(1));
        drain("ovf");

        // reset mid-packet
        beat(16'h3C00, rep(16'h3C00), 1'b0);
        beat(16'h3C00, rep(16'h3C00), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_vld",  W'(bus.out_valid), W'(0));
        chk("mrst_rdy",  W'(bus.in_ready), W'(1));
        chk("mrst_k",    W'(bus.out_k), W'(0));
        chk("mrst_data", bus.out_data, W'(0));
        beat(16'h3C00, rep(16'h4000), 1'b1);
        chk("mrst2_data", bus.out_data, rep(16'h4000));
        chk("mrst2_k",    W'(bus.out_k), W'(1));
        drain("mrst2");

`ifdef TMUL_ACC_INIT_EN
        // seeded first beat: 4 + 2*1
        bus.c_load = 1'b1;
        bus.c_row  = rep(16'h4400);
        beat(16'h4000, rep(16'h3C00), 1'b1);
        bus.c_load = 1'b0;
        chk("seed_data", bus.out_data, rep(16'h4600));
        drain("seed");
        // c_load on a later beat is ignored
        beat(16'h3C00, rep(16'h3C00), 1'b0);
        bus.c_load = 1'b1;
        beat(16'h3C00, rep(16'h3C00), 1'b1);
        bus.c_load = 1'b0;
        chk("seed2_data", bus.out_data, rep(16'h4000));
        drain("seed2");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
